// File: rtl/sat_hit_collector_if.sv
// Candidate-sample input and hit-FIFO drain signals of sat_hit_collector.
// master: checker side and host; slave: the collector.
interface sat_hit_collector_if #(
    parameter int ID_W = 32
);
    logic            in_valid;
    logic [ID_W-1:0] in_id;
    logic            in_x;
    logic            out_valid;
    logic            out_ready;
    logic [ID_W-1:0] out_id;

    modport master (
        output in_valid, in_id, in_x, out_ready,
        input  out_valid, out_id
    );

    modport slave (
        input  in_valid, in_id, in_x, out_ready,
        output out_valid, out_id
    );
endinterface

// File: rtl/sat_hit_collector.sv
// Samples checker results, counts trials/hits/drops and buffers hit IDs.
// Ports: clk, rst_n, start, stop, bus (samples + FIFO drain), counters, state, full.
module sat_hit_collector #(
    parameter int ID_W  = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    sat_hit_collector_if.slave bus,
    output logic [CNT_W-1:0] trial_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [1:0]       state,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic             full_q, full_d;
    logic [CNT_W-1:0] trial_q, trial_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic sample, hit, pop, push, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // start wins over everything: no sample, no pop in that cycle
    always_comb begin
        sample = (state_q == RUN) && bus.in_valid && !start;
        hit    = sample && bus.in_x;
        pop    = vld_q && bus.out_ready && !start;
        // a full FIFO still accepts a hit when its head leaves this cycle
        push   = hit && (!full_q || pop);
        drop   = hit && full_q && !pop;
    end

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        cnt_d = cnt_q;
        if (start) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            if (push && !pop)
                cnt_d = cnt_q + 1'b1;
            else if (pop && !push)
                cnt_d = cnt_q - 1'b1;
        end
        vld_d  = (cnt_d != '0);
        full_d = (cnt_d == DEPTH_C);
    end

    always_comb begin
        trial_d = trial_q;
        hit_d   = hit_q;
        drop_d  = drop_q;
        if (start) begin
            trial_d = '0;
            hit_d   = '0;
            drop_d  = '0;
        end else begin
            if (sample) trial_d = sat_inc(trial_q);
            if (hit)    hit_d   = sat_inc(hit_q);
            if (drop)   drop_d  = sat_inc(drop_q);
        end
    end

    // DRAIN leaves on the edge that removes the last entry
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                IDLE:  state_d = IDLE;
                RUN:   if (stop) state_d = DRAIN;
                DRAIN: if (cnt_d == '0) state_d = DONE;
                DONE:  state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            full_q  <= 1'b0;
            trial_q <= '0;
            hit_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            full_q  <= full_d;
            trial_q <= trial_d;
            hit_q   <= hit_d;
            drop_q  <= drop_d;
        end
    end

    // storage needs no reset: out_id is gated by the valid flag
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= bus.in_id;
    end

    assign bus.out_valid = vld_q;
    assign bus.out_id    = vld_q ? mem_q[rd_q] : '0;
    assign full          = full_q;
    assign state         = state_q;
    assign trial_cnt     = trial_q;
    assign hit_cnt       = hit_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_sat_hit_collector.sv
// Scoreboard bench for sat_hit_collector: two instances, CNT_W=32 and CNT_W=4.
// Expected pop IDs are queued at stimulus time and checked by monitors.
module tb_sat_hit_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1, start, stop;
    logic rst_n2 = 1'b1, start2, stop2;

    logic [31:0] tc, hc, dc;
    logic [1:0]  st;
    logic        fl;
    logic [3:0]  tc2, hc2, dc2;
    logic [1:0]  st2;
    logic        fl2;

    sat_hit_collector_if #(.ID_W(32)) bus ();
    sat_hit_collector_if #(.ID_W(32)) bus2 ();

    sat_hit_collector #(.ID_W(32), .DEPTH(8), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .bus(bus), .trial_cnt(tc), .hit_cnt(hc), .drop_cnt(dc),
        .state(st), .full(fl)
    );

    sat_hit_collector #(.ID_W(32), .DEPTH(8), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n2), .start(start2), .stop(stop2),
        .bus(bus2), .trial_cnt(tc2), .hit_cnt(hc2), .drop_cnt(dc2),
        .state(st2), .full(fl2)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp2_q[$];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !start && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none",
                         bus.out_id);
            end else begin
                chk("pop_id", {32'd0, bus.out_id}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n2 && !start2 && bus2.out_valid && bus2.out_ready) begin
            if (exp2_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop2_unexpected: got %0h expected none",
                         bus2.out_id);
            end else begin
                chk("pop2_id", {32'd0, bus2.out_id},
                    {32'd0, exp2_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input logic [31:0] id, input logic x, input logic exp_push);
        bus.in_valid = 1'b1;
        bus.in_id    = id;
        bus.in_x     = x;
        if (exp_push) exp_q.push_back(id);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic smp2(input logic [31:0] id, input logic exp_push);
        bus2.in_valid = 1'b1;
        bus2.in_id    = id;
        bus2.in_x     = 1'b1;
        if (exp_push) exp2_q.push_back(id);
        tick();
        bus2.in_valid = 1'b0;
    endtask

    initial begin
        start = 0; stop = 0;
        start2 = 0; stop2 = 0;
        bus.in_valid = 0; bus.in_id = '0; bus.in_x = 0; bus.out_ready = 0;
        bus2.in_valid = 0; bus2.in_id = '0; bus2.in_x = 0; bus2.out_ready = 0;
        rst_n = 0;
        rst_n2 = 0;
        #1;
        chk("rst_state", {62'd0, st}, 64'd0);
        chk("rst_trial", {32'd0, tc}, 64'd0);
        chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_id", {32'd0, bus.out_id}, 64'd0);
        chk("rst_full", {63'd0, fl}, 64'd0);
        tick(); tick();
        rst_n = 1;
        rst_n2 = 1;
        tick();

        // 1: mixed hits, buffered then drained in order
        start = 1; exp_q.delete(); tick(); start = 0;
        chk("t1_state_run", {62'd0, st}, 64'd1);
        smp(32'd1, 1'b1, 1'b1);
        smp(32'd2, 1'b0, 1'b0);
        smp(32'd3, 1'b1, 1'b1);
        smp(32'd4, 1'b1, 1'b1);
        smp(32'd5, 1'b0, 1'b0);
        chk("t1_trial", {32'd0, tc}, 64'd5);
        chk("t1_hit", {32'd0, hc}, 64'd3);
        chk("t1_drop", {32'd0, dc}, 64'd0);
        chk("t1_head", {32'd0, bus.out_id}, 64'd1);
        chk("t1_valid", {63'd0, bus.out_valid}, 64'd1);
        bus.out_ready = 1;
        tick(); tick(); tick();
        bus.out_ready = 0;
        chk("t1_empty", {63'd0, bus.out_valid}, 64'd0);
        chk("t1_q_used", 64'(exp_q.size()), 64'd0);

        // 2: overflow with host stalled
        for (int i = 0; i < 10; i++) begin
            smp(32'd100 + 32'(i), 1'b1, i < 8);
            if (i == 6) chk("t2_not_full7", {63'd0, fl}, 64'd0);
            if (i == 7) chk("t2_full8", {63'd0, fl}, 64'd1);
        end
        chk("t2_drop", {32'd0, dc}, 64'd2);
        chk("t2_hit", {32'd0, hc}, 64'd13);
        chk("t2_trial", {32'd0, tc}, 64'd15);

        // 3: full FIFO, push and pop together
        bus.out_ready = 1;
        smp(32'd200, 1'b1, 1'b1);
        bus.out_ready = 0;
        chk("t3_full", {63'd0, fl}, 64'd1);
        chk("t3_drop", {32'd0, dc}, 64'd2);
        chk("t3_head", {32'd0, bus.out_id}, 64'd101);
        bus.out_ready = 1;
        for (int i = 0; i < 8; i++) tick();
        bus.out_ready = 0;
        chk("t3_empty", {63'd0, bus.out_valid}, 64'd0);
        chk("t3_nfull", {63'd0, fl}, 64'd0);
        chk("t3_q_used", 64'(exp_q.size()), 64'd0);

        // 4: stop, drain, DONE
        smp(32'd300, 1'b1, 1'b1);
        smp(32'd301, 1'b1, 1'b1);
        smp(32'd302, 1'b1, 1'b1);
        stop = 1; tick(); stop = 0;
        chk("t4_drain", {62'd0, st}, 64'd2);
        bus.out_ready = 1;
        bus.in_valid = 1; bus.in_x = 1; bus.in_id = 32'd999;
        tick();
        chk("t4_drain_p1", {62'd0, st}, 64'd2);
        tick();
        chk("t4_drain_p2", {62'd0, st}, 64'd2);
        tick();
        chk("t4_done", {62'd0, st}, 64'd3);
        bus.in_valid = 0;
        bus.out_ready = 0;
        chk("t4_trial", {32'd0, tc}, 64'd19);
        chk("t4_hit", {32'd0, hc}, 64'd17);
        chk("t4_drop", {32'd0, dc}, 64'd2);
        chk("t4_empty", {63'd0, bus.out_valid}, 64'd0);
        stop = 1; tick(); stop = 0;
        chk("t4_stop_ignored", {62'd0, st}, 64'd3);

        // 5: start beats stop and a same-cycle hit
        start = 1; exp_q.delete(); tick(); start = 0;
        chk("t5_run", {62'd0, st}, 64'd1);
        chk("t5_trial0", {32'd0, tc}, 64'd0);
        for (int i = 0; i < 4; i++) smp(32'd400 + 32'(i), 1'b1, 1'b1);
        chk("t5_head", {32'd0, bus.out_id}, 64'd400);
        start = 1; stop = 1;
        bus.in_valid = 1; bus.in_x = 1; bus.in_id = 32'd500;
        exp_q.delete();
        tick();
        start = 0; stop = 0; bus.in_valid = 0;
        chk("t5_state", {62'd0, st}, 64'd1);
        chk("t5_trial", {32'd0, tc}, 64'd0);
        chk("t5_hit", {32'd0, hc}, 64'd0);
        chk("t5_drop", {32'd0, dc}, 64'd0);
        chk("t5_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t5_out_id", {32'd0, bus.out_id}, 64'd0);

        // 6: saturation on 4-bit counters, then async reset
        start2 = 1; exp2_q.delete(); tick(); start2 = 0;
        bus2.out_ready = 1;
        for (int i = 0; i < 20; i++) smp2(32'd600 + 32'(i), 1'b1);
        tick();
        bus2.out_ready = 0;
        chk("t6_trial_sat", {60'd0, tc2}, 64'd15);
        chk("t6_hit_sat", {60'd0, hc2}, 64'd15);
        chk("t6_drop", {60'd0, dc2}, 64'd0);
        chk("t6_empty", {63'd0, bus2.out_valid}, 64'd0);
        chk("t6_q_used", 64'(exp2_q.size()), 64'd0);
        smp2(32'd700, 1'b1);
        smp2(32'd701, 1'b1);
        bus2.in_valid = 1; bus2.in_x = 1; bus2.in_id = 32'd702;
        #2;
        rst_n2 = 0;
        exp2_q.delete();
        #1;
        chk("t6_rst_state", {62'd0, st2}, 64'd0);
        chk("t6_rst_trial", {60'd0, tc2}, 64'd0);
        chk("t6_rst_hit", {60'd0, hc2}, 64'd0);
        chk("t6_rst_valid", {63'd0, bus2.out_valid}, 64'd0);
        chk("t6_rst_out_id", {32'd0, bus2.out_id}, 64'd0);
        chk("t6_rst_full", {63'd0, fl2}, 64'd0);
        bus2.in_valid = 0;
        tick();
        rst_n2 = 1;
        tick();
        chk("t6_post_idle", {62'd0, st2}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
